// File: rtl/rca_pkg.sv
// Shared types and default sizing for the multi-cycle ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; c_msb_in is the carry into the top bit,
// used by the top level to derive signed overflow.
module rca_chunk
  import rca_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/rca_multicycle.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle through a single rca_chunk.
// Define RCA_MC_OVF_EN to add the registered signed-overflow output.
module rca_multicycle
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             sub_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef RCA_MC_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_q;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic [CHUNK-1:0] ch_s;
  logic             ch_cout;
`ifdef RCA_MC_OVF_EN
  logic             ch_cmsb;
`endif

  assign ch_a = op_a[idx*CHUNK +: CHUNK];
  assign ch_b = op_b[idx*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (ch_a),
    .b        (ch_b),
    .cin      (carry_q),
    .s        (ch_s),
    .cout     (ch_cout),
`ifdef RCA_MC_OVF_EN
    .c_msb_in (ch_cmsb)
`else
    .c_msb_in ()
`endif
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Subtract is done as src1 + ~src2 + 1, so the inversion happens at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef RCA_MC_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= src1;
            op_b    <= src2 ^ {WIDTH{sub_flag}};
            carry_q <= sub_flag;
            idx     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          sum[idx*CHUNK +: CHUNK] <= ch_s;
          carry_q <= ch_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            carry_out <= ch_cout;
`ifdef RCA_MC_OVF_EN
            overflow  <= ch_cout ^ ch_cmsb;
`endif
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_multicycle.sv
// Self-checking bench: 16/4 instance for the main scenarios, 8/8 instance for single-chunk.
module tb_rca_multicycle;
  import rca_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, sub_flag, out_valid, out_ready, carry_out, overflow;
  logic [15:0] src1, src2, sum;

  logic        in_valid_8, in_ready_8, sub_flag_8, out_valid_8, out_ready_8, carry_out_8;
  logic [7:0]  src1_8, src2_8, sum_8;
`ifdef RCA_MC_OVF_EN
  logic        overflow_8;
`endif

  int checks = 0;
  int failures = 0;

  rca_multicycle #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .sub_flag(sub_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out)
`ifdef RCA_MC_OVF_EN
    , .overflow(overflow)
`endif
  );

`ifndef RCA_MC_OVF_EN
  assign overflow = 1'b0;
`endif

  rca_multicycle #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_8), .in_ready(in_ready_8),
    .src1(src1_8), .src2(src2_8), .sub_flag(sub_flag_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8),
    .sum(sum_8), .carry_out(carry_out_8)
`ifdef RCA_MC_OVF_EN
    , .overflow(overflow_8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                output logic [15:0] s, output logic c, output logic v);
    int ua, ub, r, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= 65536);
      sr = sa + sb;
    end
    s = r[15:0];
    v = (sr > 32767) || (sr < -32768);
  endfunction

  // Drives one operation on the 16-bit DUT and returns what it produced.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input bit scramble, output logic [15:0] s, output logic c,
                        output logic v, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    src1      = a;
    src2      = b;
    sub_flag  = sub;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (scramble) begin
        in_valid = 1'($urandom);
        src1     = 16'($urandom);
        src2     = 16'($urandom);
        sub_flag = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    s = sum;
    c = carry_out;
    v = overflow;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%0b sum=%h carry=%0b ovf=%0b, want 0/0000/0/0",
               out_valid, sum, carry_out, overflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready_8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b/%0b want 1/1", in_ready, in_ready_8);
    end
  endtask

  task automatic test_add_carry();
    logic [15:0] s; logic c, v; int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL add_latency: got %0d want 4", lat);
    end
    checks++;
    if (s !== 16'h0000 || c !== 1'b1 || v !== 1'b0) begin
      failures++;
      $display("FAIL add_ffff_1: sum=%h c=%0b v=%0b want 0000/1/0", s, c, v);
    end
  endtask

  task automatic test_sub();
    logic [15:0] s; logic c, v; int lat;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, s, c, v, lat);
    checks++;
    if (s !== 16'hFFFE || c !== 1'b0) begin
      failures++;
      $display("FAIL sub_5_7: sum=%h c=%0b want fffe/0", s, c);
    end
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0, s, c, v, lat);
    checks++;
    if (s !== 16'h0002 || c !== 1'b1) begin
      failures++;
      $display("FAIL sub_7_5: sum=%h c=%0b want 0002/1", s, c);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic c, v; int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
    checks++;
    if (s !== 16'h8000) begin
      failures++;
      $display("FAIL ovf_add_sum: got %h want 8000", s);
    end
`ifdef RCA_MC_OVF_EN
    checks++;
    if (v !== 1'b1) begin
      failures++;
      $display("FAIL ovf_add_flag: got %0b want 1", v);
    end
`endif
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, s, c, v, lat);
    checks++;
    if (s !== 16'h7FFF) begin
      failures++;
      $display("FAIL ovf_sub_sum: got %h want 7fff", s);
    end
`ifdef RCA_MC_OVF_EN
    checks++;
    if (v !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sub_flag: got %0b want 1", v);
    end
`endif
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; src1 = 16'h1357; src2 = 16'h2468; sub_flag = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL hold_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      src1     = 16'($urandom);
      sub_flag = ~sub_flag;
      @(negedge clk);
      checks++;
      if (sum !== 16'h37BF || out_valid !== 1'b1 || in_ready !== 1'b0 || carry_out !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: sum=%h ov=%0b ir=%0b c=%0b want 37bf/1/0/0",
                 i, sum, out_valid, in_ready, carry_out);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] s; logic c, v; int lat; bit stale;
    @(negedge clk);
    in_valid = 1'b1; src1 = 16'hAAAA; src2 = 16'h5555; sub_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== 16'h0 || out_valid !== 1'b0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: sum=%h ov=%0b c=%0b v=%0b want 0000/0/0/0",
               sum, out_valid, carry_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL abort_stale: out_valid/in_ready wrong after reset, want 0/1");
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, s, c, v, lat);
    checks++;
    if (s !== 16'h2345 || c !== 1'b0 || lat !== 4) begin
      failures++;
      $display("FAIL abort_next_op: sum=%h c=%0b lat=%0d want 2345/0/4", s, c, lat);
    end
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    in_valid_8 = 1'b1; src1_8 = 8'h80; src2_8 = 8'h80; sub_flag_8 = 1'b0; out_ready_8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_8 = 1'b0;
    lat = 0;
    while (out_valid_8 !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 1 || sum_8 !== 8'h00 || carry_out_8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_add: lat=%0d sum=%h c=%0b want 1/00/1", lat, sum_8, carry_out_8);
    end
    @(negedge clk);
    checks++;
    if (out_valid_8 !== 1'b0 || in_ready_8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_release: out_valid=%0b in_ready=%0b want 0/1", out_valid_8, in_ready_8);
    end
    out_ready_8 = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] a, b, s, es; logic sub, c, v, ec, ev; int lat;
    for (int n = 0; n < 40; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
      if (n < 4) begin
        a = (n[0]) ? 16'h8000 : 16'h7FFF;
        b = (n[1]) ? 16'hFFFF : 16'h8000;
      end
      run_op(a, b, sub, 1'b1, s, c, v, lat);
      model(a, b, sub, es, ec, ev);
`ifndef RCA_MC_OVF_EN
      ev = 1'b0;
`endif
      checks++;
      if (s !== es || c !== ec || v !== ev || lat !== 4) begin
        failures++;
        $display("FAIL random[%0d] %h %s %h: got sum=%h c=%0b v=%0b lat=%0d want %h/%0b/%0b/4",
                 n, a, sub ? "-" : "+", b, s, c, v, lat, es, ec, ev);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; src1 = '0; src2 = '0; sub_flag = 1'b0; out_ready = 1'b0;
    in_valid_8 = 1'b0; src1_8 = '0; src2_8 = '0; sub_flag_8 = 1'b0; out_ready_8 = 1'b0;
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow();
    test_hold();
    test_reset_abort();
    test_width8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
